// File: rtl/qkv_bram_read_arbiter_pkg.sv
// Shared types and helpers for the Q/K/V BRAM Port B read arbiter.
package qkv_bram_read_arbiter_pkg;

  // The search helper works on a fixed-size view; NUM_REQ is capped at 8.
  localparam int unsigned MaxReq  = 8;
  localparam int unsigned MaxIdxW = 3;

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } arb_state_e;

  // First set bit of req[num_req-1:0], searching upward from ptr with wrap-around.
  // Returns 0 when nothing is set; callers qualify the result with |req.
  function automatic logic [MaxIdxW-1:0] rr_first_set(input logic [MaxReq-1:0]  req,
                                                      input logic [MaxIdxW-1:0] ptr,
                                                      input int unsigned        num_req);
    logic [MaxIdxW-1:0] idx;
    logic               found;
    int unsigned        j;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      j = 32'(ptr) + k;
      if (j >= num_req) j = j - num_req;
      if ((k < num_req) && !found && req[j[MaxIdxW-1:0]]) begin
        found = 1'b1;
        idx   = j[MaxIdxW-1:0];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/qkv_bram_read_arbiter_if.sv
// Engine/BRAM-facing bundle of the read arbiter. The master side is the fetch engines
// plus the BRAM read data; the slave side is the arbiter itself.
interface qkv_bram_read_arbiter_if #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 256
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            rd_en_in;
  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr_in;
  logic [NUM_REQ-1:0]            gnt;
  logic                          bram_enb;
  logic [ADDR_WIDTH-1:0]         bram_addrb;
  logic [DATA_WIDTH-1:0]         bram_doutb;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic [NUM_REQ-1:0]            rd_valid;
  logic [NUM_REQ-1:0]            burst_done;
  logic                          busy;
  logic                          err;

  modport master (
    output req, rd_en_in, rd_addr_in, bram_doutb,
    input  gnt, bram_enb, bram_addrb, rd_data, rd_valid, burst_done, busy, err
  );

  modport slave (
    input  req, rd_en_in, rd_addr_in, bram_doutb,
    output gnt, bram_enb, bram_addrb, rd_data, rd_valid, burst_done, busy, err
  );
endinterface

// File: rtl/qkv_bram_read_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or above the pointer, wrapping.
module qkv_bram_read_arbiter_rr_priority_picker
  import qkv_bram_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] winner_oh_o,
  output logic [IdxW-1:0]    winner_idx_o
);
  logic [MaxIdxW-1:0] pick;

  assign pick         = rr_first_set(MaxReq'(req_i), MaxIdxW'(ptr_i), NUM_REQ);
  assign winner_idx_o = IdxW'(pick);
  assign winner_oh_o  = (|req_i) ? (NUM_REQ'(1) << pick) : '0;
endmodule

// File: rtl/qkv_bram_read_arbiter.sv
// Round-robin, burst-granular arbiter for the shared Q_K_V_buffer BRAM read port.
module qkv_bram_read_arbiter
  import qkv_bram_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ              = 3,
  parameter int unsigned ADDR_WIDTH           = 16,
  parameter int unsigned DATA_WIDTH           = 256,
  parameter int unsigned NUM_FETCHES_PER_TILE = 32,
  parameter int unsigned RD_LATENCY           = 1
) (
  input logic clk,
  input logic rst,
  qkv_bram_read_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(NUM_FETCHES_PER_TILE) + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(NUM_FETCHES_PER_TILE - 1);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic [NUM_REQ-1:0]    vld_q [RD_LATENCY];
  logic [NUM_REQ-1:0]    vld_d [RD_LATENCY];

  logic [NUM_REQ-1:0]    pick_oh;
  logic [IdxW-1:0]       pick_idx;
  logic [ADDR_WIDTH-1:0] owner_addr;
  logic                  in_burst;
  logic                  fwd_en;
  logic                  last_beat;
  logic [NUM_REQ-1:0]    illegal_en;

  qkv_bram_read_arbiter_rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_picker (
    .req_i        (bus.req),
    .ptr_i        (ptr_q),
    .winner_oh_o  (pick_oh),
    .winner_idx_o (pick_idx)
  );

  assign in_burst   = (state_q == StBurst);
  assign owner_addr = bus.rd_addr_in[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign fwd_en     = in_burst && bus.rd_en_in[owner_q];
  assign last_beat  = fwd_en && (cnt_q == LastBeat);
  // In BURST gnt_q is exactly the owner's one-hot, so it doubles as the legal-enable mask.
  assign illegal_en = bus.rd_en_in & ~(in_burst ? gnt_q : '0);

  // Arbitration, burst bookkeeping and sticky error next-state.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    addr_hold_d = addr_hold_q;
    err_d       = err_q | (|illegal_en);
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d = StBurst;
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          ptr_d   = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : IdxW'(pick_idx + 1'b1);
          cnt_d   = '0;
        end
      end
      StBurst: begin
        addr_hold_d = owner_addr;
        // A last beat wins over a simultaneous req drop: it counts as a completed burst.
        if (last_beat || !bus.req[owner_q]) begin
          state_d = StIdle;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (fwd_en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Owner tag pipeline matching the BRAM read latency.
  always_comb begin
    vld_d[0] = fwd_en ? gnt_q : '0;
    for (int i = 1; i < RD_LATENCY; i++) vld_d[i] = vld_q[i-1];
  end

  // State registers; reset drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      addr_hold_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) vld_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      addr_hold_q <= addr_hold_d;
      for (int i = 0; i < RD_LATENCY; i++) vld_q[i] <= vld_d[i];
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.bram_enb   = fwd_en;
  assign bus.bram_addrb = in_burst ? owner_addr : addr_hold_q;
  assign bus.rd_data    = bus.bram_doutb;
  assign bus.rd_valid   = vld_q[RD_LATENCY-1];
  assign bus.burst_done = last_beat ? gnt_q : '0;
  assign bus.busy       = in_burst;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_qkv_bram_read_arbiter.sv
// Directed bench: two arbiters (read latency 1 and 2) driven by identical stimulus.
module tb_qkv_bram_read_arbiter;
  localparam int unsigned NR = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned NF = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR-1:0] rd_en;
  logic [AW-1:0] addr [NR];
  logic [DW-1:0] dout1, dout2a, dout2b;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  qkv_bram_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  qkv_bram_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

  assign if1.req        = req;
  assign if2.req        = req;
  assign if1.rd_en_in   = rd_en;
  assign if2.rd_en_in   = rd_en;
  assign if1.rd_addr_in = {addr[2], addr[1], addr[0]};
  assign if2.rd_addr_in = {addr[2], addr[1], addr[0]};
  assign if1.bram_doutb = dout1;
  assign if2.bram_doutb = dout2b;

  qkv_bram_read_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_FETCHES_PER_TILE(NF), .RD_LATENCY(1)
  ) u_dut_l1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  qkv_bram_read_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_FETCHES_PER_TILE(NF), .RD_LATENCY(2)
  ) u_dut_l2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  // BRAM models preloaded with word == address.
  always @(posedge clk) begin
    if (if1.bram_enb) dout1 <= DW'(if1.bram_addrb);
    if (if2.bram_enb) dout2a <= DW'(if2.bram_addrb);
    dout2b <= dout2a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    rd_en = '0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({if1.gnt, if1.rd_valid, if1.burst_done, if1.bram_enb, if1.busy, if1.err} !== '0) begin
      n_err++;
      $display("FAIL reset_l1_outs: got gnt=%b vld=%b done=%b enb=%b busy=%b err=%b want all 0",
               if1.gnt, if1.rd_valid, if1.burst_done, if1.bram_enb, if1.busy, if1.err);
    end
    n_vec++;
    if (if1.bram_addrb !== '0) begin
      n_err++; $display("FAIL reset_l1_addrb: got %0d want 0", if1.bram_addrb);
    end
    n_vec++;
    if ({if2.gnt, if2.rd_valid, if2.burst_done, if2.bram_enb, if2.busy, if2.err} !== '0) begin
      n_err++;
      $display("FAIL reset_l2_outs: got gnt=%b vld=%b done=%b enb=%b busy=%b err=%b want all 0",
               if2.gnt, if2.rd_valid, if2.burst_done, if2.bram_enb, if2.busy, if2.err);
    end
    n_vec++;
    if (if2.bram_addrb !== '0) begin
      n_err++; $display("FAIL reset_l2_addrb: got %0d want 0", if2.bram_addrb);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 3'b010;
    #1;
    n_vec++;
    if (if1.gnt !== 3'b000) begin
      n_err++; $display("FAIL single_gnt_pre: got %b want 000", if1.gnt);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      rd_en   = 3'b010;
      addr[1] = AW'(10 + k);
      #1;
      if (k == 0) begin
        n_vec++;
        if (if1.gnt !== 3'b010) begin
          n_err++; $display("FAIL single_gnt: got %b want 010", if1.gnt);
        end
      end
      n_vec++;
      if (if1.bram_enb !== 1'b1 || if1.bram_addrb !== AW'(10 + k)) begin
        n_err++;
        $display("FAIL single_beat%0d: got enb=%b addr=%0d want enb=1 addr=%0d",
                 k, if1.bram_enb, if1.bram_addrb, 10 + k);
      end
      n_vec++;
      if (if1.burst_done !== ((k == 3) ? 3'b010 : 3'b000)) begin
        n_err++; $display("FAIL single_done%0d: got %b want %b", k, if1.burst_done,
                          (k == 3) ? 3'b010 : 3'b000);
      end
      n_vec++;
      if (k == 0) begin
        if (if1.rd_valid !== 3'b000) begin
          n_err++; $display("FAIL single_vld0: got %b want 000", if1.rd_valid);
        end
      end else if (if1.rd_valid !== 3'b010 || if1.rd_data !== DW'(10 + k - 1)) begin
        n_err++; $display("FAIL single_vld%0d: got vld=%b data=%0d want vld=010 data=%0d",
                          k, if1.rd_valid, if1.rd_data, 10 + k - 1);
      end
      if (k == 1) begin
        n_vec++;
        if (if2.rd_valid !== 3'b000) begin
          n_err++; $display("FAIL single_l2_lag: got %b want 000", if2.rd_valid);
        end
      end
      tick();
    end
    req   = '0;
    rd_en = '0;
    #1;
    n_vec++;
    if (if1.gnt !== 3'b000 || if1.busy !== 1'b0) begin
      n_err++; $display("FAIL single_release: got gnt=%b busy=%b want 000/0", if1.gnt, if1.busy);
    end
    n_vec++;
    if (if1.rd_valid !== 3'b010 || if1.rd_data !== DW'(13)) begin
      n_err++; $display("FAIL single_last_data: got vld=%b data=%0d want 010/13",
                        if1.rd_valid, if1.rd_data);
    end
    tick();
    n_vec++;
    if (if1.rd_valid !== 3'b000 || if2.rd_valid !== 3'b010) begin
      n_err++; $display("FAIL single_tail: got l1=%b l2=%b want 000/010",
                        if1.rd_valid, if2.rd_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g;
    do_reset();
    req = 3'b111;
    tick();
    for (int b = 0; b < 4; b++) begin
      exp_g = NR'(1) << (b % 3);
      for (int k = 0; k < 4; k++) begin
        rd_en = exp_g;
        #1;
        if (k == 0) begin
          n_vec++;
          if (if1.gnt !== exp_g) begin
            n_err++; $display("FAIL rr_gnt_b%0d: got %b want %b", b, if1.gnt, exp_g);
          end
        end
        if (k == 3) begin
          n_vec++;
          if (if1.burst_done !== exp_g) begin
            n_err++; $display("FAIL rr_done_b%0d: got %b want %b", b, if1.burst_done, exp_g);
          end
        end
        tick();
      end
      rd_en = '0;
      if (b == 3) req = '0;
      #1;
      n_vec++;
      if (if1.gnt !== 3'b000) begin
        n_err++; $display("FAIL rr_gap_b%0d: got %b want 000", b, if1.gnt);
      end
      tick();
    end
  endtask

  task automatic test_gapped();
    do_reset();
    req = 3'b100;
    tick();
    for (int c = 0; c < 7; c++) begin
      rd_en   = (c % 2 == 0) ? 3'b100 : 3'b000;
      addr[2] = AW'(c);
      #1;
      if (c == 0) begin
        n_vec++;
        if (if1.gnt !== 3'b100) begin
          n_err++; $display("FAIL gap_gnt: got %b want 100", if1.gnt);
        end
      end
      n_vec++;
      if (if1.bram_enb !== (c % 2 == 0) ||
          if1.burst_done !== ((c == 6) ? 3'b100 : 3'b000)) begin
        n_err++; $display("FAIL gap_c%0d: got enb=%b done=%b want enb=%b done=%b", c,
                          if1.bram_enb, if1.burst_done, (c % 2 == 0),
                          (c == 6) ? 3'b100 : 3'b000);
      end
      tick();
    end
    req   = '0;
    rd_en = '0;
    #1;
    n_vec++;
    if (if1.gnt !== 3'b000) begin
      n_err++; $display("FAIL gap_release: got %b want 000", if1.gnt);
    end
  endtask

  task automatic test_abort();
    do_reset();
    req = 3'b011;
    tick();
    for (int k = 0; k < 2; k++) begin
      rd_en   = 3'b001;
      addr[0] = AW'(20 + k);
      #1;
      if (k == 1) begin
        n_vec++;
        if (if1.rd_valid !== 3'b001 || if1.rd_data !== DW'(20)) begin
          n_err++; $display("FAIL abort_vld0: got vld=%b data=%0d want 001/20",
                            if1.rd_valid, if1.rd_data);
        end
      end
      tick();
    end
    req   = 3'b010;
    rd_en = '0;
    #1;
    n_vec++;
    if (if1.burst_done !== 3'b000 || if1.gnt !== 3'b001) begin
      n_err++; $display("FAIL abort_cycle: got done=%b gnt=%b want 000/001",
                        if1.burst_done, if1.gnt);
    end
    n_vec++;
    if (if1.rd_valid !== 3'b001 || if1.rd_data !== DW'(21)) begin
      n_err++; $display("FAIL abort_vld1: got vld=%b data=%0d want 001/21",
                        if1.rd_valid, if1.rd_data);
    end
    tick();
    n_vec++;
    if (if1.gnt !== 3'b000 || if1.busy !== 1'b0 || if1.burst_done !== 3'b000) begin
      n_err++; $display("FAIL abort_idle: got gnt=%b busy=%b done=%b want 000/0/000",
                        if1.gnt, if1.busy, if1.burst_done);
    end
    tick();
    n_vec++;
    if (if1.gnt !== 3'b010) begin
      n_err++; $display("FAIL abort_next_gnt: got %b want 010", if1.gnt);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_protocol_err();
    do_reset();
    req = 3'b001;
    tick();
    rd_en   = 3'b101;
    addr[0] = AW'(30);
    addr[2] = AW'(99);
    #1;
    n_vec++;
    if (if1.bram_enb !== 1'b1 || if1.bram_addrb !== AW'(30) || if1.err !== 1'b0) begin
      n_err++; $display("FAIL perr_fwd: got enb=%b addr=%0d err=%b want 1/30/0",
                        if1.bram_enb, if1.bram_addrb, if1.err);
    end
    tick();
    rd_en = 3'b100;
    #1;
    n_vec++;
    if (if1.err !== 1'b1 || if1.bram_enb !== 1'b0 || if1.rd_valid !== 3'b001) begin
      n_err++; $display("FAIL perr_set: got err=%b enb=%b vld=%b want 1/0/001",
                        if1.err, if1.bram_enb, if1.rd_valid);
    end
    tick();
    rd_en = '0;
    #1;
    n_vec++;
    if (if1.rd_valid !== 3'b000 || if1.err !== 1'b1) begin
      n_err++; $display("FAIL perr_novld: got vld=%b err=%b want 000/1", if1.rd_valid, if1.err);
    end
    req = '0;
    tick();
    tick();
    n_vec++;
    if (if1.err !== 1'b1 || if1.busy !== 1'b0) begin
      n_err++; $display("FAIL perr_sticky: got err=%b busy=%b want 1/0", if1.err, if1.busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 3'b010;
    tick();
    for (int k = 0; k < 3; k++) begin
      rd_en   = 3'b010;
      addr[1] = AW'(40 + k);
      if (k == 2) begin
        rst = 1'b1;
        req = 3'b110;
      end
      tick();
    end
    rst   = 1'b0;
    rd_en = '0;
    #1;
    n_vec++;
    if ({if2.gnt, if2.rd_valid, if2.burst_done, if2.bram_enb, if2.busy, if2.err} !== '0 ||
        if2.bram_addrb !== '0) begin
      n_err++;
      $display("FAIL rstmid_l2: got gnt=%b vld=%b done=%b enb=%b busy=%b err=%b addr=%0d want 0",
               if2.gnt, if2.rd_valid, if2.burst_done, if2.bram_enb, if2.busy, if2.err,
               if2.bram_addrb);
    end
    n_vec++;
    if ({if1.gnt, if1.rd_valid, if1.burst_done, if1.bram_enb, if1.busy} !== '0 ||
        if1.bram_addrb !== '0) begin
      n_err++; $display("FAIL rstmid_l1: got gnt=%b vld=%b addr=%0d want 0",
                        if1.gnt, if1.rd_valid, if1.bram_addrb);
    end
    tick();
    n_vec++;
    if (if1.gnt !== 3'b010 || if2.gnt !== 3'b010 || if2.rd_valid !== 3'b000) begin
      n_err++; $display("FAIL rstmid_regrant: got l1=%b l2=%b l2vld=%b want 010/010/000",
                        if1.gnt, if2.gnt, if2.rd_valid);
    end
    req = '0;
    tick();
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    rd_en = '0;
    for (int i = 0; i < NR; i++) addr[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_gapped();
    test_abort();
    test_protocol_err();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/qkv_bram_read_arbiter.md
Name: qkv_bram_read_arbiter

Overview:
- Shares the single read port (Port B) of the Q_K_V_buffer BRAM among NUM_REQ fetch engines, e.g. Q, K and V fetch_logic_gen instances.
- Grants the port a whole tile burst at a time, in round-robin order.
- Forwards the owner's address and enable to the BRAM, and routes returned data back with a per-requester valid tag.
- Sits between the fetch engines and the BRAM, inside the fetch/BRAM top level.

Parameters:
NUM_REQ, 3, number of requesting fetch engines (2..8)
ADDR_WIDTH, 16, BRAM address width
DATA_WIDTH, 256, BRAM data width
NUM_FETCHES_PER_TILE, 32, read beats per granted burst (>=1)
RD_LATENCY, 1, BRAM enb-to-doutb latency in cycles (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-engine burst request, held high until burst_done or abort
rd_en_in  in  NUM_REQ  per-engine read enable
rd_addr_in  in  NUM_REQ*ADDR_WIDTH  per-engine read address; engine i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
gnt  out  NUM_REQ  one-hot registered grant
bram_enb  out  1  BRAM Port B enable
bram_addrb  out  ADDR_WIDTH  BRAM Port B address
bram_doutb  in  DATA_WIDTH  BRAM Port B read data
rd_data  out  DATA_WIDTH  read data, a passthrough of bram_doutb
rd_valid  out  NUM_REQ  one-hot data-valid tag
burst_done  out  NUM_REQ  one-cycle pulse on the owner's last beat
busy  out  1  high while in BURST state
err  out  1  sticky protocol-error flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: gnt=0, bram_enb=0, bram_addrb=0, rd_valid=0, burst_done=0, busy=0, err=0. The FSM goes to IDLE, the beat counter to 0, and the round-robin pointer to 0. The valid pipeline is flushed, so in-flight reads are dropped.
- IDLE state:
  - If req != 0, pick the first set bit searching from the RR pointer upward, with wrap-around.
  - Next cycle: gnt becomes one-hot for the winner, owner is recorded, state becomes BURST.
  - The RR pointer becomes winner+1 mod NUM_REQ.
- BURST state:
  - bram_enb = rd_en_in[owner]; bram_addrb = owner's address slice. Both are combinational from the registered owner.
  - Outside BURST: bram_enb=0 and bram_addrb is held at its last value.
  - The beat counter increments on each forwarded enable.
  - Last beat: forwarded enable with counter == NUM_FETCHES_PER_TILE-1. On that cycle burst_done[owner]=1. Next cycle: gnt=0, counter=0, state becomes IDLE.
- Burst gap: there is at least one gnt-low cycle between consecutive bursts (arbitration cycle). Worst-case wait for a requester is (NUM_REQ-1) bursts.
- Abort: if req[owner] drops during BURST, gnt clears next cycle and state becomes IDLE with no burst_done. A rd_en_in[owner] on the abort cycle is still forwarded.
- Simultaneous last beat and req[owner] drop: treated as a completed burst, so burst_done pulses.
- Beat counter width: $clog2(NUM_FETCHES_PER_TILE)+1; it never wraps within a burst.
- Read return:
  - A RD_LATENCY-deep shift register carries the one-hot owner tag qualified by bram_enb.
  - rd_valid[i] is high exactly RD_LATENCY cycles after the enb beat it answers, even after the grant has moved on.
- Protocol error: rd_en_in[i]=1 while i is not the current owner, or any rd_en_in in IDLE, sets err. err stays set until rst. Such enables are never forwarded.
- Request changes: req bits of non-owners may rise or fall freely and affect only the next arbitration.

Decomposition:
- Shared package: the FSM state encoding (IDLE, BURST) and a helper function for round-robin first-set-bit search from a pointer. Width constants are derived from the parameters.
- One sub-module: rr_priority_picker. Inputs are req and the pointer; outputs are a one-hot winner and its index, purely combinational.
- The tag pipeline and FSM stay in the top module.

Test Plan:
- Single requester (NUM_FETCHES_PER_TILE=4): req[1]=1, addrs 10..13 with enable every cycle after gnt. Expect gnt=3'b010 one cycle after req, bram_addrb 10,11,12,13, burst_done[1] on beat 4, gnt=0 the next cycle. rd_valid[1] asserts 4 times at a 1-cycle lag; with BRAM preloaded word=addr, rd_data=10..13.
- Round-robin fairness: req=3'b111 held through 3 bursts after reset. Expect grant order 0,1,2, then 0 again, with exactly one gnt-low cycle between bursts.
- Gapped beats: owner 2 toggles rd_en_in 1,0,1,0,... Expect burst_done only after the 4th enabled beat (cycle 7 of the burst); the counter ignores idle cycles.
- Abort: owner 0 drops req after 2 beats. Expect no burst_done, gnt clears next cycle, next arbitration grants requester 1 if it is requesting. rd_valid[0] is still delivered for the 2 issued beats.
- Protocol error: rd_en_in[2]=1 while owner=0. Expect err=1 held, bram_enb unaffected by bit 2, and no rd_valid[2].
- Reset mid-burst: assert rst for 1 cycle at beat 2 with RD_LATENCY=2. Expect all outputs 0 the next cycle, no rd_valid for the in-flight beats, and the RR pointer restarting so req=3'b110 grants requester 1.
